mips_16_wb_trace_buffer: RTL and testbench
==========================================

Name: mips_16_wb_trace_buffer

Overview:
- Hardware producer side of the register-writeback observation path.
- Snoops the core's writeback port (reg_write_en / reg_write_dest / reg_write_data), timestamps each architectural register write and buffers it in a FIFO.
- Streams the buffered records to a consumer (bench monitor or debug readout) over a valid/ready handshake.
- Sits beside mips_16_core_top; it never drives anything into the core.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- TS_WIDTH, 16: timestamp counter width.
- DROP_R0, 1: when 1, writes to register 0 are not captured.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous reset, active-high
- capture_en  input  1  capture enable; 0 ignores the writeback port
- reg_write_en  input  1  core writeback enable
- reg_write_dest  input  3  writeback register index
- reg_write_data  input  16  writeback data
- trace_valid  output  1  head record available
- trace_ready  input  1  consumer accepts head record
- trace_data  output  TS_WIDTH+19  record {timestamp, dest[2:0], data[15:0]}, timestamp in MSBs
- fill_level  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky; a record was dropped
- drop_count  output  16  dropped-record count, saturating
- clear_overflow  input  1  clears overflow and drop_count

Behaviour:
- Reset (async, on rst high), all outputs 0 while rst held:
  - trace_valid=0, trace_data=0, fill_level=0, overflow=0, drop_count=0.
  - Timestamp counter=0, read/write pointers=0.
  - Reset mid-stream discards all buffered records.
- Timestamp:
  - Free-running, increments by 1 every clk after reset deassertion.
  - Wraps from all-ones to 0.
  - A record carries the counter value of the cycle whose rising edge samples reg_write_en=1.
- Push request condition, sampled at the rising edge: capture_en & reg_write_en & !(DROP_R0 & reg_write_dest==0).
- Pop occurs at the rising edge when trace_valid & trace_ready.
- FIFO is show-ahead:
  - trace_valid = (fill_level != 0).
  - trace_data = head entry, registered or memory-read with no extra latency.
  - A record pushed at edge N is visible on trace_valid/trace_data after edge N (one-cycle latency from writeback to output).
- Handshake rules:
  - trace_data holds stable while trace_valid=1 and trace_ready=0.
  - trace_ready while trace_valid=0 has no effect.
  - Consumer may hold trace_ready high permanently.
- Simultaneous push and pop:
  - Not full: both occur, fill_level unchanged.
  - Full: pop frees a slot, push accepted, fill_level stays DEPTH, no drop.
  - Empty: push only; no bypass, so the record appears next cycle.
- Overflow, on a push request while full with no pop:
  - Record discarded.
  - overflow set to 1.
  - drop_count increments, saturating at 16'hFFFF.
  - FIFO contents untouched.
- clear_overflow at an edge:
  - overflow=0 and drop_count=0.
  - If a drop occurs in the same cycle, clear wins: overflow=1, drop_count=1.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from fill_level.
- capture_en=0 blocks new pushes only; buffered records keep draining.

Test Plan:
- Reset, then capture_en=1 and three writebacks at timestamps 5/6/7: r1=16'h1234, r2=16'hABCD, r7=16'h0001, trace_ready=1.
  -> trace_valid one cycle after each write; trace_data={16'd5,3'd1,16'h1234}, {16'd6,3'd2,16'hABCD}, {16'd7,3'd7,16'h0001} in order; fill_level returns to 0.
- DROP_R0=1, writeback r0=16'hFFFF, then r3=16'h0042.
  -> only the r3 record appears; fill_level peaks at 1.
- trace_ready=0, 20 consecutive writebacks with DEPTH=16.
  -> fill_level=16; overflow=1; drop_count=4; first-pushed record stable on trace_data.
  -> Then trace_ready=1 for 16 cycles: exactly the first 16 records, in order.
- FIFO full, trace_ready=1 and a writeback in the same cycle.
  -> fill_level stays 16, drop_count unchanged, new record is last out.
- rst pulsed asynchronously (mid-cycle) with fill_level=9.
  -> trace_valid and fill_level drop to 0 immediately; timestamp restarts at 0; prior records never emitted.
- overflow=1, drop_count=3, clear_overflow asserted coincident with another drop.
  -> overflow=1, drop_count=1 next cycle.
  -> clear_overflow alone then yields overflow=0, drop_count=0.

Source files
------------

// File: rtl/mips_16_wb_trace_buffer.sv
`timescale 1ns/1ps
// Writeback trace buffer: timestamps every captured register write and queues it
// in a show-ahead FIFO that drains to a consumer over a valid/ready handshake.
module mips_16_wb_trace_buffer #(
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 16,
    parameter int DROP_R0  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     capture_en,
    input  logic                     reg_write_en,
    input  logic [2:0]               reg_write_dest,
    input  logic [15:0]              reg_write_data,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [TS_WIDTH+18:0]     trace_data,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    input  logic                     clear_overflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int REC_W = TS_WIDTH + 19;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       fill_q, fill_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic [REC_W-1:0]    mem_q [DEPTH];

    logic                push_req;
    logic                full;
    logic                empty;
    logic                pop;
    logic                push;
    logic                drop;
    logic [REC_W-1:0]    rec;

    always_comb begin
        push_req = capture_en & reg_write_en
                   & ~((DROP_R0 != 0) && (reg_write_dest == 3'd0));
        full     = (fill_q == CW'(DEPTH));
        empty    = (fill_q == '0);
        pop      = ~empty & trace_ready;
        // A pop at the same edge frees a slot, so a full FIFO can still accept.
        push     = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
        rec      = {ts_q, reg_write_dest, reg_write_data};
    end

    always_comb begin
        ts_d       = ts_q + TS_WIDTH'(1);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   fill_d = fill_q + CW'(1);
            2'b01:   fill_d = fill_q - CW'(1);
            default: fill_d = fill_q;
        endcase

        // Clear takes priority but a drop in the same cycle is still recorded.
        if (clear_overflow) begin
            overflow_d = drop;
            drop_cnt_d = drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            overflow_d = 1'b1;
            drop_cnt_d = sat_inc16(drop_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage carries no reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rec;
        end
    end

    always_comb begin
        trace_valid = ~empty;
        trace_data  = empty ? '0 : mem_q[rd_ptr_q];
        fill_level  = fill_q;
        overflow    = overflow_q;
        drop_count  = drop_cnt_q;
    end

endmodule

// File: tb/tb_mips_16_wb_trace_buffer.sv
`timescale 1ns/1ps
// Scoreboard bench for the writeback trace buffer: a queue-based reference model
// predicts records and status; a negedge monitor compares against the DUT.
module tb_mips_16_wb_trace_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  dest = 3'd0;
    logic [15:0] wdata = 16'd0;
    logic        rdy = 1'b0;
    logic        clr = 1'b0;

    logic        trace_valid;
    logic [34:0] trace_data;
    logic [4:0]  fill_level;
    logic        overflow;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    mips_16_wb_trace_buffer #(.DEPTH(16), .TS_WIDTH(16), .DROP_R0(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .capture_en     (ce),
        .reg_write_en   (we),
        .reg_write_dest (dest),
        .reg_write_data (wdata),
        .trace_valid    (trace_valid),
        .trace_ready    (rdy),
        .trace_data     (trace_data),
        .fill_level     (fill_level),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clear_overflow (clr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          m_cnt;
    bit          m_ovf;
    int          m_drops;
    int          m_ts;
    logic [34:0] exp_q[$];
    bit          m_req, m_pop, m_drop;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt   = 0;
            m_ovf   = 1'b0;
            m_drops = 0;
            m_ts    = 0;
            exp_q.delete();
        end else begin
            m_req  = ce && we && (dest != 3'd0);
            m_pop  = (m_cnt > 0) && rdy;
            m_drop = m_req && (m_cnt == DEPTH) && !m_pop;
            if (m_req && !m_drop) begin
                exp_q.push_back({m_ts[15:0], dest, wdata});
                m_cnt++;
            end
            if (m_pop) m_cnt--;
            if (clr) begin
                m_ovf   = m_drop;
                m_drops = m_drop ? 1 : 0;
            end else if (m_drop) begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops++;
            end
            m_ts = (m_ts + 1) % 65536;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", 64'(trace_valid), 64'd0);
            chk("rst_fill", 64'(fill_level), 64'd0);
            chk("rst_data", 64'(trace_data), 64'd0);
            chk("rst_ovf", 64'(overflow), 64'd0);
            chk("rst_drops", 64'(drop_count), 64'd0);
        end else begin
            chk("valid", 64'(trace_valid), 64'(m_cnt != 0));
            chk("fill", 64'(fill_level), 64'(m_cnt));
            chk("ovf", 64'(overflow), 64'(m_ovf));
            chk("drops", 64'(drop_count), 64'(m_drops));
            if (m_cnt != 0 && exp_q.size() > 0) begin
                chk("data", 64'(trace_data), 64'(exp_q[0]));
                if (rdy) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input bit c, input bit w, input logic [2:0] d,
                         input logic [15:0] v, input bit r, input bit k);
        ce = c; we = w; dest = d; wdata = v; rdy = r; clr = k;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [34:0] rec;
        logic [34:0] head_exp;

        // Reset and first three writebacks at timestamps 5, 6, 7
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) drive(1, 0, 3'd0, 16'h0, 1, 0);
        drive(1, 1, 3'd1, 16'h1234, 1, 0);
        rec = {16'd5, 3'd1, 16'h1234};
        chk("t1_v1", 64'(trace_valid), 64'd1);
        chk("t1_r1", 64'(trace_data), 64'(rec));
        drive(1, 1, 3'd2, 16'hABCD, 1, 0);
        rec = {16'd6, 3'd2, 16'hABCD};
        chk("t1_r2", 64'(trace_data), 64'(rec));
        drive(1, 1, 3'd7, 16'h0001, 1, 0);
        rec = {16'd7, 3'd7, 16'h0001};
        chk("t1_r7", 64'(trace_data), 64'(rec));
        drive(1, 0, 3'd0, 16'h0, 1, 0);
        chk("t1_empty", 64'(fill_level), 64'd0);

        // Register 0 writes are filtered
        drive(1, 1, 3'd0, 16'hFFFF, 0, 0);
        chk("t2_r0", 64'(fill_level), 64'd0);
        drive(1, 1, 3'd3, 16'h0042, 0, 0);
        chk("t2_r3_fill", 64'(fill_level), 64'd1);
        rec = {m_ts[15:0] - 16'd1, 3'd3, 16'h0042};
        chk("t2_r3_data", 64'(trace_data), 64'(rec));
        drive(1, 0, 3'd0, 16'h0, 1, 0);
        chk("t2_drain", 64'(fill_level), 64'd0);

        // Overfill with consumer stalled
        head_exp = {m_ts[15:0], 3'd1, 16'd0};
        for (int i = 0; i < 20; i++) drive(1, 1, 3'(i % 7 + 1), 16'(i), 0, 0);
        chk("t3_fill", 64'(fill_level), 64'd16);
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_drops", 64'(drop_count), 64'd4);
        chk("t3_head", 64'(trace_data), 64'(head_exp));

        // Full with simultaneous pop and push: no drop
        drive(1, 1, 3'd5, 16'hBEEF, 1, 0);
        chk("t4_fill", 64'(fill_level), 64'd16);
        chk("t4_drops", 64'(drop_count), 64'd4);

        // Clear alone, then clear coincident with a drop
        drive(1, 0, 3'd0, 16'h0, 0, 1);
        chk("t5_clr_ovf", 64'(overflow), 64'd0);
        chk("t5_clr_drops", 64'(drop_count), 64'd0);
        for (int i = 0; i < 3; i++) drive(1, 1, 3'd6, 16'(16'h100 + i), 0, 0);
        chk("t5_drops3", 64'(drop_count), 64'd3);
        drive(1, 1, 3'd6, 16'h0200, 0, 1);
        chk("t5_clrdrop_ovf", 64'(overflow), 64'd1);
        chk("t5_clrdrop_drops", 64'(drop_count), 64'd1);
        drive(1, 0, 3'd0, 16'h0, 0, 1);
        chk("t5_clr2_ovf", 64'(overflow), 64'd0);
        chk("t5_clr2_drops", 64'(drop_count), 64'd0);
        repeat (17) drive(1, 0, 3'd0, 16'h0, 1, 0);
        chk("t5_drained", 64'(fill_level), 64'd0);

        // Asynchronous reset mid-cycle with nine records buffered
        for (int i = 0; i < 9; i++) drive(1, 1, 3'd2, 16'(16'h300 + i), 0, 0);
        chk("t6_fill9", 64'(fill_level), 64'd9);
        #1 rst = 1'b1;
        #1;
        chk("t6_async_valid", 64'(trace_valid), 64'd0);
        chk("t6_async_fill", 64'(fill_level), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive(1, 1, 3'd4, 16'h0055, 0, 0);
        rec = {16'd0, 3'd4, 16'h0055};
        chk("t6_ts_restart", 64'(trace_data), 64'(rec));
        chk("t6_fill1", 64'(fill_level), 64'd1);
        drive(1, 0, 3'd0, 16'h0, 1, 0);

        // Randomized traffic with varying consumer throughput
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 500; i++) begin
                drive($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                      3'($urandom_range(0, 7)), 16'($urandom),
                      $urandom_range(0, 5) < blk, $urandom_range(0, 49) == 0);
            end
        end
        repeat (20) drive(0, 0, 3'd0, 16'h0, 1, 0);
        chk("final_empty", 64'(fill_level), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
